// File: rtl/scene_pkg.sv
// Shared definitions for the scene RAM writer (scene_loader) and the header reader.
package scene_pkg;

    localparam int NHDR   = 11;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int HIDX_W = 4;

    localparam int H_SIZE  = 0;
    localparam int H_NUMV  = 1;
    localparam int H_NUMF  = 2;
    localparam int H_NUML  = 3;
    localparam int H_LOFF  = 4;
    localparam int H_VOFF  = 5;
    localparam int H_NVOFF = 6;
    localparam int H_FOFF  = 7;
    localparam int H_NFOFF = 8;
    localparam int H_MOFF  = 9;
    localparam int H_MFOFF = 10;

    // Largest legal scene: it fills the whole RAM.
    localparam logic [DATA_W-1:0] MAX_SIZE = {{(DATA_W-ADDR_W-1){1'b0}}, 1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_BODY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5,
        ST_TRAIL = 3'd6
    } loader_state_t;

    function automatic logic size_is_bad(input logic [DATA_W-1:0] w);
        return (w < DATA_W'(NHDR)) || (w > MAX_SIZE);
    endfunction

endpackage

// File: rtl/scene_loader.sv
// Streams host words into scene RAM port A and latches the scene header.
// Optional SCENE_LOADER_CHECKSUM_EN: expects a trailing checksum word and exposes csum.
module scene_loader
    import scene_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [ADDR_W-1:0]            address_a,
    output logic [DATA_W-1:0]            data_a,
    output logic                         wren_a,
    output logic [NHDR-1:0][DATA_W-1:0]  header,
    output logic                         busy,
    output logic                         done,
    output logic                         err
`ifdef SCENE_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]            csum
`endif
);

`ifdef SCENE_LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL_ST    = ST_TRAIL;
    localparam logic          TAIL_READY = 1'b1;
`else
    localparam loader_state_t TAIL_ST    = ST_DRAIN;
    localparam logic          TAIL_READY = 1'b0;
`endif

    loader_state_t    state_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] size_r;
    logic             accept_s;
    logic             write_s;
    logic             last_word_s;

    assign accept_s    = in_valid && in_ready;
    // The checksum trailer is consumed but never stored.
    assign write_s     = accept_s && (state_r != ST_TRAIL);
    assign last_word_s = (count_r == (size_r - CNT_W'(1'b1)));

    // Load sequencer, RAM write port, header capture and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= '0;
            size_r    <= '0;
            in_ready  <= 1'b0;
            address_a <= '0;
            data_a    <= '0;
            wren_a    <= 1'b0;
            header    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef SCENE_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            wren_a <= 1'b0;
            if (write_s) begin
                wren_a    <= 1'b1;
                address_a <= count_r[ADDR_W-1:0];
                data_a    <= in_data;
                count_r   <= count_r + CNT_W'(1'b1);
`ifdef SCENE_LOADER_CHECKSUM_EN
                csum      <= csum + in_data;
`endif
            end

            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r  <= ST_HDR;
                        count_r  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
`ifdef SCENE_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        header[count_r[HIDX_W-1:0]] <= in_data;
                        if (count_r == CNT_W'(H_SIZE)) begin
                            size_r <= in_data[CNT_W-1:0];
                            if (size_is_bad(in_data)) begin
                                state_r  <= ST_ERR;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                            end
                        end else if (count_r == CNT_W'(NHDR - 1)) begin
                            if (size_r == CNT_W'(NHDR)) begin
                                state_r  <= TAIL_ST;
                                in_ready <= TAIL_READY;
                            end else begin
                                state_r  <= ST_BODY;
                            end
                        end
                    end
                end
                ST_BODY: begin
                    if (accept_s && last_word_s) begin
                        state_r  <= TAIL_ST;
                        in_ready <= TAIL_READY;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
`ifdef SCENE_LOADER_CHECKSUM_EN
                ST_TRAIL: begin
                    if (accept_s) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_ERR;
                            err     <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
